alu_exec_stage: RTL

- Execute stage directly downstream of the ALU control decoder.
- Consumes the 3-bit ALUControl code plus operands and computes the ALU result and zero flag (zero drives beq).
- Buffers results in a small in-order FIFO behind a valid/ready handshake, so a multi-cycle or stalling consumer (writeback/branch unit) can backpressure execute without losing results.

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_core.sv | 58 +++++
 rtl/alu_exec_stage.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUControl width and operation codes.
// Imported by both the ALU control decoder and the execute stage.
package alu_pkg;

  localparam int ALU_CTRL_W = 3;

  // Codes 100, 110 and 111 are undefined and are flagged as illegal by the ALU.
  typedef enum logic [ALU_CTRL_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_op_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: (alu_control, a, b) -> (result, zero, illegal).
// Optional macro ALU_EXEC_OVF_EN adds a signed overflow output for add/sub.
import alu_pkg::*;

module alu_core #(
  parameter int WIDTH = 32
) (
  input  logic [ALU_CTRL_W-1:0] alu_control,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  output logic [WIDTH-1:0]      result,
  output logic                  zero,
`ifdef ALU_EXEC_OVF_EN
  output logic                  overflow,
`endif
  output logic                  illegal
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             slt_lt;

  assign sum    = a + b;
  assign diff   = a - b;
  assign slt_lt = $signed(a) < $signed(b);
  assign zero   = (result == '0);

  // Select the operation result; undefined codes yield zero and raise illegal.
  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (alu_control)
      ALU_ADD: result = sum;
      ALU_SUB: result = diff;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, slt_lt};
      default: begin
        result  = '0;
        illegal = 1'b1;
      end
    endcase
  end

`ifdef ALU_EXEC_OVF_EN
  // Signed overflow: add wraps when same-sign operands give a different-sign sum;
  // sub wraps when operand signs differ and the result sign departs from a.
  always_comb begin
    overflow = 1'b0;
    case (alu_control)
      ALU_ADD: overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      ALU_SUB: overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      default: overflow = 1'b0;
    endcase
  end
`endif

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: runs alu_core on accepted inputs and buffers results in an
// in-order circular FIFO behind valid/ready handshakes on both sides.
// Optional macro ALU_EXEC_OVF_EN adds a per-entry signed overflow output.
import alu_pkg::*;

module alu_exec_stage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ALU_CTRL_W-1:0] alu_control,
  input  logic [WIDTH-1:0]      src_a,
  input  logic [WIDTH-1:0]      src_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      result,
  output logic                  zero,
`ifdef ALU_EXEC_OVF_EN
  output logic                  overflow,
`endif
  output logic                  illegal
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic [WIDTH-1:0] result_q [DEPTH];
  logic [WIDTH-1:0] result_d [DEPTH];
  logic [DEPTH-1:0] zero_q, zero_d;
  logic [DEPTH-1:0] illegal_q, illegal_d;

  logic [WIDTH-1:0] core_result;
  logic             core_zero;
  logic             core_illegal;
  logic             in_fire;
  logic             out_fire;

`ifdef ALU_EXEC_OVF_EN
  logic [DEPTH-1:0] ovf_q, ovf_d;
  logic             core_overflow;
`endif

  alu_core #(.WIDTH(WIDTH)) u_alu_core (
    .alu_control (alu_control),
    .a           (src_a),
    .b           (src_b),
    .result      (core_result),
    .zero        (core_zero),
`ifdef ALU_EXEC_OVF_EN
    .overflow    (core_overflow),
`endif
    .illegal     (core_illegal)
  );

  // Ready depends on registered occupancy only, so a full buffer never
  // accepts in the same cycle it drains.
  assign in_ready  = (count_q != FULL_COUNT);
  assign out_valid = (count_q != '0);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Next-state for pointers and occupancy; simultaneous push/pop keeps count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (in_fire)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (out_fire) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({in_fire, out_fire})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Entry write: the ALU output is captured into the tail slot on acceptance.
  always_comb begin
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
`ifdef ALU_EXEC_OVF_EN
    ovf_d     = ovf_q;
`endif
    if (in_fire) begin
      result_d[wr_ptr_q]  = core_result;
      zero_d[wr_ptr_q]    = core_zero;
      illegal_d[wr_ptr_q] = core_illegal;
`ifdef ALU_EXEC_OVF_EN
      ovf_d[wr_ptr_q]     = core_overflow;
`endif
    end
  end

  // Control state registers with synchronous reset; buffered entries are
  // discarded simply by clearing occupancy and pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset; stale contents are never visible when empty.
  always_ff @(posedge clk) begin
    result_q  <= result_d;
    zero_q    <= zero_d;
    illegal_q <= illegal_d;
`ifdef ALU_EXEC_OVF_EN
    ovf_q     <= ovf_d;
`endif
  end

  // Head outputs are forced to zero while the buffer is empty.
  always_comb begin
    result  = '0;
    zero    = 1'b0;
    illegal = 1'b0;
    if (out_valid) begin
      result  = result_q[rd_ptr_q];
      zero    = zero_q[rd_ptr_q];
      illegal = illegal_q[rd_ptr_q];
    end
  end

`ifdef ALU_EXEC_OVF_EN
  // Overflow is also held low during reset cycles.
  always_comb begin
    overflow = 1'b0;
    if (out_valid && !rst) overflow = ovf_q[rd_ptr_q];
  end
`endif

endmodule
